// File: rtl/commit_trace_buffer_if.sv
// Commit-log / trace-stream interface for commit_trace_buffer.
// slave  : the trace buffer (consumes commit records, produces the trace stream).
// master : the surrounding environment (write-back stage plus trace sink).
interface commit_trace_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  // write-back commit log
  logic                   log_trace;
  logic [ADDR_WIDTH-1:0]  pc_log;
  logic [INSTR_WIDTH-1:0] instruction_log;
  logic                   reg_we;
  logic [REG_ADDR_W-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   mem_access_log;
  logic                   mem_we_log;
  logic [ADDR_WIDTH-1:0]  mem_addr_log;
  logic [DATA_WIDTH-1:0]  mem_write_data_log;

  // trace sink stream
  logic                   trace_ready;
  logic                   trace_valid;
  logic [31:0]            trace_seq;
  logic [ADDR_WIDTH-1:0]  trace_pc;
  logic [INSTR_WIDTH-1:0] trace_instr;
  logic                   trace_rd_we;
  logic [REG_ADDR_W-1:0]  trace_rd_addr;
  logic [DATA_WIDTH-1:0]  trace_rd_data;
  logic                   trace_mem_access;
  logic                   trace_mem_we;
  logic [ADDR_WIDTH-1:0]  trace_mem_addr;
  logic [DATA_WIDTH-1:0]  trace_mem_wdata;

  // status
  logic [CW-1:0]          trace_count;
  logic                   trace_stall;
  logic [15:0]            trace_drop_cnt;

  modport slave (
    input  log_trace, pc_log, instruction_log, reg_we, rd_addr, wb_data,
           mem_access_log, mem_we_log, mem_addr_log, mem_write_data_log,
           trace_ready,
    output trace_valid, trace_seq, trace_pc, trace_instr, trace_rd_we,
           trace_rd_addr, trace_rd_data, trace_mem_access, trace_mem_we,
           trace_mem_addr, trace_mem_wdata, trace_count, trace_stall,
           trace_drop_cnt
  );

  modport master (
    output log_trace, pc_log, instruction_log, reg_we, rd_addr, wb_data,
           mem_access_log, mem_we_log, mem_addr_log, mem_write_data_log,
           trace_ready,
    input  trace_valid, trace_seq, trace_pc, trace_instr, trace_rd_we,
           trace_rd_addr, trace_rd_data, trace_mem_access, trace_mem_we,
           trace_mem_addr, trace_mem_wdata, trace_count, trace_stall,
           trace_drop_cnt
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures retired-instruction records from the write-back
// commit log into a DEPTH-entry FIFO and drains them in order over a
// valid/ready trace stream. Records arriving while full are counted as drops.
// All stream outputs come straight from registers (head record is pre-fetched).
// Optional feature macro: TRACE_MEM_FIELDS_EN -- when defined, the memory
// access fields are stored per entry; otherwise trace_mem_* are tied to 0.
module commit_trace_buffer #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 8
) (
  input  logic         clk_i,
  input  logic         arst_i,
  commit_trace_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]            seq;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   rd_we;
    logic [REG_ADDR_W-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
`ifdef TRACE_MEM_FIELDS_EN
    logic                   mem_access;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
`endif
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            new_rec;
  rec_t            head;
  rec_t            head_next;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [31:0]     seq;
  logic [15:0]     drop_cnt;
  logic            valid;
  logic            stall;

  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign full = (count == CW'(DEPTH));
  assign pop  = valid & bus.trace_ready;
  assign push = bus.log_trace & (~full | pop);
  assign drop = bus.log_trace & full & ~pop;

  // Assemble the incoming record, tagged with the current sequence number.
  always_comb begin
    new_rec         = '0;
    new_rec.seq     = seq;
    new_rec.pc      = bus.pc_log;
    new_rec.instr   = bus.instruction_log;
    new_rec.rd_we   = bus.reg_we;
    new_rec.rd_addr = bus.rd_addr;
    new_rec.rd_data = bus.wb_data;
`ifdef TRACE_MEM_FIELDS_EN
    new_rec.mem_access = bus.mem_access_log;
    new_rec.mem_we     = bus.mem_we_log;
    new_rec.mem_addr   = bus.mem_addr_log;
    new_rec.mem_wdata  = bus.mem_write_data_log;
`endif
  end

  // Next occupancy from the push/pop pair; push+pop together keeps count.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Read pointer after this cycle's pop.
  always_comb begin
    if (pop) begin
      rd_ptr_next = rd_ptr + PW'(1);
    end else begin
      rd_ptr_next = rd_ptr;
    end
  end

  // Pre-fetch the next head record; forward the new record when it lands in
  // the head slot this cycle (FIFO empty, or one entry being popped).
  always_comb begin
    if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = new_rec;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Record storage; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // Pointers, occupancy, sequence and drop counters, registered status outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= 32'd0;
      drop_cnt <= 16'd0;
      valid    <= 1'b0;
      stall    <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      valid  <= (count_next != CW'(0));
      stall  <= (count_next == CW'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        seq    <= seq + 32'd1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Head record register driving the trace fields.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head <= '0;
    end else begin
      head <= head_next;
    end
  end

  assign bus.trace_valid    = valid;
  assign bus.trace_seq      = head.seq;
  assign bus.trace_pc       = head.pc;
  assign bus.trace_instr    = head.instr;
  assign bus.trace_rd_we    = head.rd_we;
  assign bus.trace_rd_addr  = head.rd_addr;
  assign bus.trace_rd_data  = head.rd_data;
  assign bus.trace_count    = count;
  assign bus.trace_stall    = stall;
  assign bus.trace_drop_cnt = drop_cnt;

`ifdef TRACE_MEM_FIELDS_EN
  assign bus.trace_mem_access = head.mem_access;
  assign bus.trace_mem_we     = head.mem_we;
  assign bus.trace_mem_addr   = head.mem_addr;
  assign bus.trace_mem_wdata  = head.mem_wdata;
`else
  assign bus.trace_mem_access = 1'b0;
  assign bus.trace_mem_we     = 1'b0;
  assign bus.trace_mem_addr   = '0;
  assign bus.trace_mem_wdata  = '0;
`endif

endmodule
